// File: rtl/gray_decoder.sv
// Gray-code position tracker: decodes a 4-bit Gray counter, reports single
// up/down steps, counts full revolutions and latches illegal transitions.
module gray_decoder #(
  parameter int WRAP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [3:0]        gray_i,
  input  logic              clr_i,
  output logic [3:0]        bin_o,
  output logic              valid_o,
  output logic              up_o,
  output logic              dn_o,
  output logic              err_o,
  output logic [WRAP_W-1:0] wrap_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  function automatic logic [3:0] gray_to_bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  state_t            state_r, state_s;
  logic [3:0]        bin_r, bin_s;
  logic              valid_r, valid_s;
  logic              up_r, up_s;
  logic              dn_r, dn_s;
  logic              err_r, err_s;
  logic [WRAP_W-1:0] wrap_r, wrap_s;
  logic [3:0]        dec_s;
  logic [3:0]        delta_s;

  assign dec_s   = gray_to_bin(gray_i);
  assign delta_s = dec_s - bin_r;

  // Next-state and next-output computation; clear overrides any sample.
  always_comb begin
    state_s = state_r;
    bin_s   = bin_r;
    up_s    = 1'b0;
    dn_s    = 1'b0;
    err_s   = err_r;
    wrap_s  = wrap_r;
    if (clr_i) begin
      state_s = IDLE;
      err_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (en_i) begin
            bin_s   = dec_s;
            state_s = TRACK;
          end else begin
            state_s = IDLE;
          end
        end
        TRACK: begin
          if (en_i) begin
            case (delta_s)
              4'd0: begin
                bin_s = bin_r;
              end
              4'd1: begin
                bin_s = dec_s;
                up_s  = 1'b1;
                if (bin_r == 4'd15) begin
                  wrap_s = wrap_r + WRAP_ONE;
                end else begin
                  wrap_s = wrap_r;
                end
              end
              4'd15: begin
                bin_s = dec_s;
                dn_s  = 1'b1;
                if (bin_r == 4'd0) begin
                  wrap_s = wrap_r - WRAP_ONE;
                end else begin
                  wrap_s = wrap_r;
                end
              end
              default: begin
                err_s   = 1'b1;
                state_s = FAULT;
              end
            endcase
          end else begin
            state_s = TRACK;
          end
        end
        FAULT: begin
          err_s   = 1'b1;
          state_s = FAULT;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
    valid_s = (state_s == TRACK);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
      bin_r   <= 4'd0;
      valid_r <= 1'b0;
      up_r    <= 1'b0;
      dn_r    <= 1'b0;
      err_r   <= 1'b0;
      wrap_r  <= {WRAP_W{1'b0}};
    end else begin
      state_r <= state_s;
      bin_r   <= bin_s;
      valid_r <= valid_s;
      up_r    <= up_s;
      dn_r    <= dn_s;
      err_r   <= err_s;
      wrap_r  <= wrap_s;
    end
  end

  assign bin_o      = bin_r;
  assign valid_o    = valid_r;
  assign up_o       = up_r;
  assign dn_o       = dn_r;
  assign err_o      = err_r;
  assign wrap_cnt_o = wrap_r;

endmodule

// File: tb/tb_gray_decoder.sv
// Self-checking bench for gray_decoder: directed scenarios followed by random
// stimulus, compared against a position-level reference model.
module tb_gray_decoder;

  localparam int WRAP_W = 8;
  localparam int WRAP_M = 256;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              en_i = 1'b0;
  logic [3:0]        gray_i = 4'd0;
  logic              clr_i = 1'b0;
  logic [3:0]        bin_o;
  logic              valid_o;
  logic              up_o;
  logic              dn_o;
  logic              err_o;
  logic [WRAP_W-1:0] wrap_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 = no reference, 1 = tracking, 2 = faulted.
  int m_mode = 0;
  int m_pos  = 0;
  int m_wrap = 0;
  bit m_up = 1'b0, m_dn = 1'b0, m_err = 1'b0;

  gray_decoder #(.WRAP_W(WRAP_W)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .en_i      (en_i),
    .gray_i    (gray_i),
    .clr_i     (clr_i),
    .bin_o     (bin_o),
    .valid_o   (valid_o),
    .up_o      (up_o),
    .dn_o      (dn_o),
    .err_o     (err_o),
    .wrap_cnt_o(wrap_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [3:0] gray_of(input int pos);
    logic [3:0] p;
    p = 4'(pos);
    return p ^ (p >> 1);
  endfunction

  // Position of a Gray word found by searching the Gray sequence.
  function automatic int pos_of(input logic [3:0] g);
    for (int i = 0; i < 16; i++) begin
      if (gray_of(i) == g) return i;
    end
    return 0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit en, input logic [3:0] g, input bit clr, input bit rn);
    int p, d;
    m_up = 1'b0;
    m_dn = 1'b0;
    p = pos_of(g);
    if (!rn) begin
      m_mode = 0; m_pos = 0; m_wrap = 0; m_err = 1'b0;
    end else if (clr) begin
      m_mode = 0; m_err = 1'b0;
    end else if (en && m_mode == 0) begin
      m_pos = p; m_mode = 1;
    end else if (en && m_mode == 1) begin
      d = (p - m_pos + 16) % 16;
      if (d == 1) begin
        m_up = 1'b1;
        if (m_pos == 15) m_wrap = (m_wrap + 1) % WRAP_M;
        m_pos = p;
      end else if (d == 15) begin
        m_dn = 1'b1;
        if (m_pos == 0) m_wrap = (m_wrap + WRAP_M - 1) % WRAP_M;
        m_pos = p;
      end else if (d != 0) begin
        m_err = 1'b1; m_mode = 2;
      end
    end
  endtask

  task automatic step(input string tag, input bit en, input logic [3:0] g,
                      input bit clr, input bit rn);
    @(negedge clk_i);
    en_i = en; gray_i = g; clr_i = clr; rst_n_i = rn;
    @(posedge clk_i);
    model_edge(en, g, clr, rn);
    #1;
    check_eq({tag, ".bin"},   32'(bin_o),      32'(m_pos));
    check_eq({tag, ".valid"}, 32'(valid_o),    32'(m_mode == 1));
    check_eq({tag, ".up"},    32'(up_o),       32'(m_up));
    check_eq({tag, ".dn"},    32'(dn_o),       32'(m_dn));
    check_eq({tag, ".err"},   32'(err_o),      32'(m_err));
    check_eq({tag, ".wrap"},  32'(wrap_cnt_o), 32'(m_wrap));
  endtask

  initial begin
    int r, tgt;
    bit en, clr, rn;
    step("reset", 1'b0, 4'b0000, 1'b0, 1'b0);
    step("load0", 1'b1, 4'b0000, 1'b0, 1'b1);
    check_eq("load0.valid_abs", 32'(valid_o), 32'd1);
    step("up1", 1'b1, 4'b0001, 1'b0, 1'b1);
    step("up2", 1'b1, 4'b0011, 1'b0, 1'b1);
    step("up3", 1'b1, 4'b0010, 1'b0, 1'b1);
    check_eq("up3.bin_abs", 32'(bin_o), 32'd3);
    step("idle_en0", 1'b0, 4'b0110, 1'b0, 1'b1);
    check_eq("idle_en0.up_abs", 32'(up_o), 32'd0);
    // Revolution counting across the 15/0 boundary in both directions.
    step("clr1", 1'b0, 4'b0000, 1'b1, 1'b1);
    step("load15", 1'b1, 4'b1000, 1'b0, 1'b1);
    step("wrap_up", 1'b1, 4'b0000, 1'b0, 1'b1);
    check_eq("wrap_up.abs", 32'(wrap_cnt_o), 32'd1);
    step("wrap_dn", 1'b1, 4'b1000, 1'b0, 1'b1);
    check_eq("wrap_dn.abs", 32'(wrap_cnt_o), 32'd0);
    step("clr2", 1'b0, 4'b0000, 1'b1, 1'b1);
    step("load0b", 1'b1, 4'b0000, 1'b0, 1'b1);
    step("wrap_neg", 1'b1, 4'b1000, 1'b0, 1'b1);
    check_eq("wrap_neg.abs", 32'(wrap_cnt_o), 32'd255);
    // Illegal jump, ignored samples, then clear.
    step("clr3", 1'b0, 4'b0000, 1'b1, 1'b1);
    step("load0c", 1'b1, 4'b0000, 1'b0, 1'b1);
    step("fault", 1'b1, 4'b0011, 1'b0, 1'b1);
    check_eq("fault.err_abs", 32'(err_o), 32'd1);
    step("fault_ign1", 1'b1, 4'b0001, 1'b0, 1'b1);
    step("fault_ign2", 1'b1, 4'b0000, 1'b0, 1'b1);
    step("fault_clr", 1'b1, 4'b0001, 1'b1, 1'b1);
    check_eq("fault_clr.err_abs", 32'(err_o), 32'd0);
    // Clear beats a same-cycle sample; next sample reloads silently.
    step("load0d", 1'b1, 4'b0000, 1'b0, 1'b1);
    step("clr_en", 1'b1, 4'b0001, 1'b1, 1'b1);
    step("reload", 1'b1, 4'b0011, 1'b0, 1'b1);
    check_eq("reload.bin_abs", 32'(bin_o), 32'd2);
    // Reset beats a legal step.
    step("rst_mid", 1'b1, 4'b0010, 1'b0, 1'b0);
    check_eq("rst_mid.bin_abs", 32'(bin_o), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      tgt = (m_pos + 1) % 16;
      else if (r < 6) tgt = (m_pos + 15) % 16;
      else if (r < 7) tgt = m_pos;
      else            tgt = $urandom_range(0, 15);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 30) == 0);
      rn  = ($urandom_range(0, 150) != 0);
      step("rand", en, gray_of(tgt), clr, rn);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
